// File: rtl/lru_replacement_engine.sv
`default_nettype none
// ============================================================================
// Module   : lru_replacement_engine
// Purpose  : Per-set true-LRU age/valid tracking with a 2-cycle victim lookup.
//            Optional build macro LRU_WAY_LOCK_EN adds lock_mask way exclusion.
// Revision : 1.0
// ============================================================================
module lru_replacement_engine #(
  parameter  int NUM_WAYS = 8,
  parameter  int NUM_SETS = 16,
  localparam int WAY_W    = $clog2(NUM_WAYS),
  localparam int SET_W    = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             acc_valid,
  input  logic [SET_W-1:0] acc_set,
  input  logic [WAY_W-1:0] acc_way,
  input  logic             acc_fill,
  input  logic             inv_valid,
  input  logic [SET_W-1:0] inv_set,
  input  logic [WAY_W-1:0] inv_way,
  input  logic             vic_req,
  input  logic [SET_W-1:0] vic_req_set,
  output logic             vic_ready,
  output logic             vic_valid,
  output logic [WAY_W-1:0] vic_way,
  output logic             vic_was_valid,
  output logic             vic_none,
  input  logic             vic_ack,
  output logic             inv_drop
`ifdef LRU_WAY_LOCK_EN
  ,
  input  logic [NUM_WAYS-1:0] lock_mask
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [WAY_W-1:0] C_AGE_LRU = WAY_W'(NUM_WAYS - 1);

  // A single-set configuration still carries a 1-bit index; it is ignored.
  function automatic logic [SET_W-1:0] set_idx(input logic [SET_W-1:0] s);
    if (NUM_SETS == 1) begin
      return '0;
    end
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Age / valid state
  // --------------------------------------------------------------------------
  logic [WAY_W-1:0]    age_q   [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]    age_d   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
  logic                inv_drop_q;
  logic                inv_drop_d;

  logic [SET_W-1:0] acc_s;
  logic [SET_W-1:0] inv_s;
  logic [WAY_W-1:0] acc_old;
  logic [WAY_W-1:0] inv_old;
  logic             collide;
  logic             inv_apply;

  assign acc_s     = set_idx(acc_set);
  assign inv_s     = set_idx(inv_set);
  assign acc_old   = age_q[acc_s][acc_way];
  assign inv_old   = age_q[inv_s][inv_way];
  assign collide   = acc_valid && inv_valid && (acc_s == inv_s);
  assign inv_apply = inv_valid && !collide;

  always_comb begin
    age_d      = age_q;
    valid_d    = valid_q;
    inv_drop_d = collide;
    for (int s = 0; s < NUM_SETS; s++) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (acc_valid && (acc_s == SET_W'(s))) begin
          // Promote to MRU; everything younger than its old age slides back one.
          if (acc_way == WAY_W'(w)) begin
            age_d[s][w] = '0;
            if (acc_fill) begin
              valid_d[s][w] = 1'b1;
            end
          end else if (age_q[s][w] < acc_old) begin
            age_d[s][w] = age_q[s][w] + 1'b1;
          end
        end else if (inv_apply && (inv_s == SET_W'(s))) begin
          // Demote to LRU; everything older than its old age moves forward one.
          if (inv_way == WAY_W'(w)) begin
            age_d[s][w]   = C_AGE_LRU;
            valid_d[s][w] = 1'b0;
          end else if (age_q[s][w] > inv_old) begin
            age_d[s][w] = age_q[s][w] - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          age_q[s][w] <= WAY_W'(w);
        end
        valid_q[s] <= '0;
      end
      inv_drop_q <= 1'b0;
    end else begin
      age_q      <= age_d;
      valid_q    <= valid_d;
      inv_drop_q <= inv_drop_d;
    end
  end

  // --------------------------------------------------------------------------
  // Victim selection on the captured set
  // --------------------------------------------------------------------------
  logic [NUM_WAYS-1:0] elig;
  logic [SET_W-1:0]    vic_set_q;
  logic [SET_W-1:0]    vic_set_d;
  logic [NUM_WAYS-1:0] rd_valid;
  logic                inv_hit;
  logic [WAY_W-1:0]    inv_pick;
  logic                lru_hit;
  logic [WAY_W-1:0]    lru_pick;
  logic [WAY_W-1:0]    lru_age;
  logic [WAY_W-1:0]    sel_way;
  logic                sel_was_valid;
  logic                sel_none;

`ifdef LRU_WAY_LOCK_EN
  assign elig = ~lock_mask;
`else
  assign elig = '1;
`endif

  assign rd_valid = valid_q[vic_set_q];

  always_comb begin
    inv_hit  = 1'b0;
    inv_pick = '0;
    lru_hit  = 1'b0;
    lru_pick = '0;
    lru_age  = '0;
    // Scan downward so the lowest-index invalid way is the last one kept.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (elig[w] && !rd_valid[w]) begin
        inv_hit  = 1'b1;
        inv_pick = WAY_W'(w);
      end
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (elig[w] && (!lru_hit || (age_q[vic_set_q][w] > lru_age))) begin
        lru_hit  = 1'b1;
        lru_age  = age_q[vic_set_q][w];
        lru_pick = WAY_W'(w);
      end
    end
    sel_none      = !(inv_hit || lru_hit);
    sel_way       = inv_hit ? inv_pick : lru_pick;
    sel_was_valid = !inv_hit && lru_hit && rd_valid[lru_pick];
  end

  // --------------------------------------------------------------------------
  // Lookup FSM
  // --------------------------------------------------------------------------
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WAY_W-1:0] vic_way_q;
  logic [WAY_W-1:0] vic_way_d;
  logic             vic_was_valid_q;
  logic             vic_was_valid_d;
  logic             vic_none_q;
  logic             vic_none_d;

  always_comb begin
    state_d         = state_q;
    vic_set_d       = vic_set_q;
    vic_way_d       = vic_way_q;
    vic_was_valid_d = vic_was_valid_q;
    vic_none_d      = vic_none_q;
    case (state_q)
      ST_IDLE: begin
        if (vic_req) begin
          state_d   = ST_READ;
          vic_set_d = set_idx(vic_req_set);
        end
      end
      ST_READ: begin
        state_d         = ST_RESP;
        vic_way_d       = sel_way;
        vic_was_valid_d = sel_was_valid;
        vic_none_d      = sel_none;
      end
      ST_RESP: begin
        if (vic_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      vic_set_q       <= '0;
      vic_way_q       <= '0;
      vic_was_valid_q <= 1'b0;
      vic_none_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      vic_set_q       <= vic_set_d;
      vic_way_q       <= vic_way_d;
      vic_was_valid_q <= vic_was_valid_d;
      vic_none_q      <= vic_none_d;
    end
  end

  assign vic_ready     = (state_q == ST_IDLE);
  assign vic_valid     = (state_q == ST_RESP);
  assign vic_way       = vic_way_q;
  assign vic_was_valid = vic_was_valid_q;
  assign vic_none      = vic_none_q;
  assign inv_drop      = inv_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_lru_replacement_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_lru_replacement_engine
// Purpose  : Directed self-checking bench for lru_replacement_engine (4 ways, 4 sets).
// Revision : 1.0
// ============================================================================
module tb_lru_replacement_engine;

  localparam int NUM_WAYS = 4;
  localparam int NUM_SETS = 4;
  localparam int WAY_W    = 2;
  localparam int SET_W    = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             acc_valid;
  logic [SET_W-1:0] acc_set;
  logic [WAY_W-1:0] acc_way;
  logic             acc_fill;
  logic             inv_valid;
  logic [SET_W-1:0] inv_set;
  logic [WAY_W-1:0] inv_way;
  logic             vic_req;
  logic [SET_W-1:0] vic_req_set;
  logic             vic_ready;
  logic             vic_valid;
  logic [WAY_W-1:0] vic_way;
  logic             vic_was_valid;
  logic             vic_none;
  logic             vic_ack;
  logic             inv_drop;
`ifdef LRU_WAY_LOCK_EN
  logic [NUM_WAYS-1:0] lock_mask;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  lru_replacement_engine #(
    .NUM_WAYS(NUM_WAYS),
    .NUM_SETS(NUM_SETS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .acc_valid    (acc_valid),
    .acc_set      (acc_set),
    .acc_way      (acc_way),
    .acc_fill     (acc_fill),
    .inv_valid    (inv_valid),
    .inv_set      (inv_set),
    .inv_way      (inv_way),
    .vic_req      (vic_req),
    .vic_req_set  (vic_req_set),
    .vic_ready    (vic_ready),
    .vic_valid    (vic_valid),
    .vic_way      (vic_way),
    .vic_was_valid(vic_was_valid),
    .vic_none     (vic_none),
    .vic_ack      (vic_ack),
    .inv_drop     (inv_drop)
`ifdef LRU_WAY_LOCK_EN
    ,
    .lock_mask    (lock_mask)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic acc_op(input logic [SET_W-1:0] s, input logic [WAY_W-1:0] w, input logic f);
    acc_valid = 1'b1; acc_set = s; acc_way = w; acc_fill = f;
    tick;
    acc_valid = 1'b0; acc_fill = 1'b0;
  endtask

  task automatic inv_op(input logic [SET_W-1:0] s, input logic [WAY_W-1:0] w);
    inv_valid = 1'b1; inv_set = s; inv_way = w;
    tick;
    inv_valid = 1'b0;
  endtask

  task automatic check_ages(input string tag, input logic [SET_W-1:0] s,
                            input logic [WAY_W-1:0] a0, input logic [WAY_W-1:0] a1,
                            input logic [WAY_W-1:0] a2, input logic [WAY_W-1:0] a3);
    check_val({tag, "_age0"}, dut.age_q[s][0], a0);
    check_val({tag, "_age1"}, dut.age_q[s][1], a1);
    check_val({tag, "_age2"}, dut.age_q[s][2], a2);
    check_val({tag, "_age3"}, dut.age_q[s][3], a3);
  endtask

  // Full lookup handshake: fixed 2-cycle latency, a stray vic_req during RESP, then ack.
  task automatic lookup(input logic [SET_W-1:0] s, input string tag,
                        input logic [WAY_W-1:0] e_way, input logic e_wv, input logic e_none);
    vic_req = 1'b1; vic_req_set = s;
    check_val({tag, "_ready"}, vic_ready, 1);
    tick;
    vic_req = 1'b0;
    check_val({tag, "_n1_valid"}, vic_valid, 0);
    tick;
    check_val({tag, "_valid"}, vic_valid, 1);
    check_val({tag, "_way"}, vic_way, e_way);
    check_val({tag, "_was_valid"}, vic_was_valid, e_wv);
    check_val({tag, "_none"}, vic_none, e_none);
    vic_req = 1'b1; vic_req_set = s ^ 2'd1;
    tick;
    vic_req = 1'b0;
    check_val({tag, "_hold_valid"}, vic_valid, 1);
    check_val({tag, "_hold_way"}, vic_way, e_way);
    check_val({tag, "_hold_ready"}, vic_ready, 0);
    vic_ack = 1'b1;
    tick;
    vic_ack = 1'b0;
    check_val({tag, "_ack_ready"}, vic_ready, 1);
    check_val({tag, "_ack_valid"}, vic_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    acc_valid = 1'b0; acc_set = '0; acc_way = '0; acc_fill = 1'b0;
    inv_valid = 1'b0; inv_set = '0; inv_way = '0;
    vic_req = 1'b0; vic_req_set = '0; vic_ack = 1'b0;
`ifdef LRU_WAY_LOCK_EN
    lock_mask = '0;
`endif
    tick;
    tick;
    reset = 1'b0;

    check_val("rst_ready", vic_ready, 1);
    check_val("rst_valid", vic_valid, 0);
    check_val("rst_way", vic_way, 0);
    check_val("rst_was_valid", vic_was_valid, 0);
    check_val("rst_none", vic_none, 0);
    check_val("rst_inv_drop", inv_drop, 0);
    check_ages("rst_s2", 2'd2, 2'd0, 2'd1, 2'd2, 2'd3);

    lookup(2'd0, "first", 2'd0, 1'b0, 1'b0);

    // Fill set 1 in order: ages end at 3,2,1,0.
    acc_op(2'd1, 2'd0, 1'b1);
    acc_op(2'd1, 2'd1, 1'b1);
    acc_op(2'd1, 2'd2, 1'b1);
    acc_op(2'd1, 2'd3, 1'b1);
    check_ages("fill_s1", 2'd1, 2'd3, 2'd2, 2'd1, 2'd0);
    lookup(2'd1, "full_lru", 2'd0, 1'b1, 1'b0);
    acc_op(2'd1, 2'd0, 1'b0);
    check_ages("touch_s1", 2'd1, 2'd0, 2'd3, 2'd2, 2'd1);
    lookup(2'd1, "after_touch", 2'd1, 1'b1, 1'b0);

    // Invalidate way 2 (age 2): it goes to 3, way 1 drops from 3 to 2.
    inv_op(2'd1, 2'd2);
    check_ages("inv_s1", 2'd1, 2'd0, 2'd2, 2'd3, 2'd1);
    lookup(2'd1, "after_inv", 2'd2, 1'b0, 1'b0);

    // Set 2: fill way 3 (ages 1,2,3,0), then colliding access way 1 / invalidate way 3.
    acc_op(2'd2, 2'd3, 1'b1);
    acc_valid = 1'b1; acc_set = 2'd2; acc_way = 2'd1; acc_fill = 1'b0;
    inv_valid = 1'b1; inv_set = 2'd2; inv_way = 2'd3;
    tick;
    acc_valid = 1'b0; inv_valid = 1'b0;
    check_val("coll_drop", inv_drop, 1);
    check_val("coll_w3_valid", dut.valid_q[2][3], 1);
    check_ages("coll_s2", 2'd2, 2'd2, 2'd0, 2'd3, 2'd1);
    tick;
    check_val("coll_drop_pulse", inv_drop, 0);
    lookup(2'd2, "coll_lookup", 2'd0, 1'b0, 1'b0);

    // Different sets in one cycle: both apply, no drop.
    acc_valid = 1'b1; acc_set = 2'd3; acc_way = 2'd2; acc_fill = 1'b1;
    inv_valid = 1'b1; inv_set = 2'd1; inv_way = 2'd0;
    tick;
    acc_valid = 1'b0; acc_fill = 1'b0; inv_valid = 1'b0;
    check_val("split_drop", inv_drop, 0);
    check_ages("split_s1", 2'd1, 2'd3, 2'd1, 2'd2, 2'd0);
    check_ages("split_s3", 2'd3, 2'd1, 2'd2, 2'd0, 2'd3);
    check_val("split_s1_valid", dut.valid_q[1], 4'b1010);
    check_val("split_s3_valid", dut.valid_q[3], 4'b0100);
    lookup(2'd1, "split_lookup", 2'd0, 1'b0, 1'b0);

    // Stray ack in IDLE must not start anything.
    vic_ack = 1'b1;
    tick;
    vic_ack = 1'b0;
    check_val("stray_ack_ready", vic_ready, 1);
    check_val("stray_ack_valid", vic_valid, 0);

    // Reset while RESP holds a result, with a concurrent access.
    vic_req = 1'b1; vic_req_set = 2'd1;
    tick;
    vic_req = 1'b0;
    tick;
    check_val("midrst_pre_valid", vic_valid, 1);
    reset = 1'b1;
    acc_valid = 1'b1; acc_set = 2'd1; acc_way = 2'd3; acc_fill = 1'b1;
    tick;
    reset = 1'b0; acc_valid = 1'b0; acc_fill = 1'b0;
    check_val("midrst_valid", vic_valid, 0);
    check_val("midrst_ready", vic_ready, 1);
    check_ages("midrst_s1", 2'd1, 2'd0, 2'd1, 2'd2, 2'd3);
    check_val("midrst_s1_valid", dut.valid_q[1], 4'b0000);

`ifdef LRU_WAY_LOCK_EN
    // Set 0 filled 0..3 gives ages 3,2,1,0: of unlocked ways 2/3, way 2 is oldest.
    acc_op(2'd0, 2'd0, 1'b1);
    acc_op(2'd0, 2'd1, 1'b1);
    acc_op(2'd0, 2'd2, 1'b1);
    acc_op(2'd0, 2'd3, 1'b1);
    lock_mask = 4'b0011;
    lookup(2'd0, "lock_pair", 2'd2, 1'b1, 1'b0);
    lock_mask = 4'b1111;
    lookup(2'd0, "lock_all", 2'd0, 1'b0, 1'b1);
    lock_mask = 4'b0000;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
